// File: rtl/msrv32_wb_stage_unit_if.sv
// Write-back stage bundle: retiring instruction in, register-file write port
// and data-memory response, grouped for the upstream and downstream sides.
interface msrv32_wb_stage_unit_if;
    logic        instr_valid_in;
    logic        wb_ready_out;
    logic        rf_wr_en_in;
    logic [4:0]  rd_addr_in;
    logic [2:0]  wb_mux_sel_in;
    logic [31:0] alu_result_in;
    logic [31:0] imm_in;
    logic [31:0] pc_in;
    logic [31:0] csr_data_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [1:0]  load_addr_lsb_in;
    logic [31:0] dmem_rdata_in;
    logic        dmem_rvalid_in;
    logic [31:0] rd_out;
    logic [4:0]  rd_addr_out;
    logic        wr_en_out;
    logic        load_err_out;

    modport slave (
        input  instr_valid_in, rf_wr_en_in, rd_addr_in,
        input  wb_mux_sel_in, alu_result_in, imm_in,
        input  pc_in, csr_data_in, load_size_in,
        input  load_unsigned_in, load_addr_lsb_in,
        input  dmem_rdata_in, dmem_rvalid_in,
        output wb_ready_out, rd_out, rd_addr_out,
        output wr_en_out, load_err_out
    );

    modport master (
        output instr_valid_in, rf_wr_en_in, rd_addr_in,
        output wb_mux_sel_in, alu_result_in, imm_in,
        output pc_in, csr_data_in, load_size_in,
        output load_unsigned_in, load_addr_lsb_in,
        output dmem_rdata_in, dmem_rvalid_in,
        input  wb_ready_out, rd_out, rd_addr_out,
        input  wr_en_out, load_err_out
    );
endinterface

// File: rtl/msrv32_wb_stage_unit.sv
// MS-RISCV32 write-back stage: selects the write-back source, waits for
// load data, aligns/extends it and drives the register-file write port.
module msrv32_wb_stage_unit #(
    parameter int LOAD_TIMEOUT = 15
) (
    input logic                         ms_riscv32_mp_clk_in,
    input logic                         ms_riscv32_mp_rst_in,
    msrv32_wb_stage_unit_if.slave       wb
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    localparam logic [2:0] SEL_ALU  = 3'b000;
    localparam logic [2:0] SEL_LOAD = 3'b001;
    localparam logic [2:0] SEL_IMM  = 3'b010;
    localparam logic [2:0] SEL_PC4  = 3'b011;
    localparam logic [2:0] SEL_CSR  = 3'b100;
    localparam logic [7:0] LAST_CNT = 8'(LOAD_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  ld_rd_q;
    logic [1:0]  ld_size_q;
    logic        ld_uns_q;
    logic [1:0]  ld_off_q;
    logic        ld_wq_q;
    logic [31:0] rd_q;
    logic [4:0]  rd_addr_q;
    logic        wr_en_q;
    logic        err_q;

    logic [31:0] val_d;
    logic        sel_ok_d;
    logic        wq_d;
    logic        ld_bad_d;
    logic [31:0] ld_d;
    logic [31:0] shifted;

    always_comb begin
        val_d    = 32'd0;
        sel_ok_d = 1'b1;
        case (wb.wb_mux_sel_in)
            SEL_ALU: val_d = wb.alu_result_in;
            SEL_IMM: val_d = wb.imm_in;
            SEL_PC4: val_d = wb.pc_in + 32'd4;
            SEL_CSR: val_d = wb.csr_data_in;
            default: sel_ok_d = 1'b0;
        endcase
    end

    assign wq_d = wb.rf_wr_en_in && (wb.rd_addr_in != 5'd0);

    assign ld_bad_d = (wb.load_size_in == 2'b11)
        || (wb.load_size_in == 2'b01 && wb.load_addr_lsb_in[0])
        || (wb.load_size_in == 2'b10 && wb.load_addr_lsb_in != 2'b00);

    // Offset was already validated, so shifting covers byte and half lanes.
    assign shifted = wb.dmem_rdata_in >> {ld_off_q, 3'b000};

    always_comb begin
        ld_d = wb.dmem_rdata_in;
        case (ld_size_q)
            2'b00:   ld_d = {{24{~ld_uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_d = {{16{~ld_uns_q & shifted[15]}}, shifted[15:0]};
            default: ld_d = wb.dmem_rdata_in;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            ld_rd_q   <= 5'd0;
            ld_size_q <= 2'b00;
            ld_uns_q  <= 1'b0;
            ld_off_q  <= 2'b00;
            ld_wq_q   <= 1'b0;
            rd_q      <= 32'd0;
            rd_addr_q <= 5'd0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wb.instr_valid_in) begin
                        if (wb.wb_mux_sel_in == SEL_LOAD) begin
                            ld_rd_q   <= wb.rd_addr_in;
                            ld_size_q <= wb.load_size_in;
                            ld_uns_q  <= wb.load_unsigned_in;
                            ld_off_q  <= wb.load_addr_lsb_in;
                            ld_wq_q   <= wq_d;
                            if (ld_bad_d) begin
                                err_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_LOAD;
                                cnt_q   <= 8'd0;
                            end
                        end else begin
                            rd_q      <= val_d;
                            rd_addr_q <= wb.rd_addr_in;
                            wr_en_q   <= wq_d && sel_ok_d;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (wb.dmem_rvalid_in) begin
                        rd_q      <= ld_d;
                        rd_addr_q <= ld_rd_q;
                        wr_en_q   <= ld_wq_q;
                        state_q   <= IDLE;
                    end else if (cnt_q == LAST_CNT) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign wb.wb_ready_out = (state_q == IDLE);
    assign wb.rd_out       = rd_q;
    assign wb.rd_addr_out  = rd_addr_q;
    assign wb.wr_en_out    = wr_en_q;
    assign wb.load_err_out = err_q;
endmodule

// File: tb/tb_msrv32_wb_stage_unit.sv
// Directed bench for the write-back stage: source select, loads,
// load errors, timeout and asynchronous reset.
module tb_msrv32_wb_stage_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    msrv32_wb_stage_unit_if wb ();

    msrv32_wb_stage_unit #(.LOAD_TIMEOUT(4)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .wb                   (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] sel, input logic [4:0] rd,
                      input logic [31:0] v);
        wb.instr_valid_in = 1'b1;
        wb.rf_wr_en_in    = 1'b1;
        wb.wb_mux_sel_in  = sel;
        wb.rd_addr_in     = rd;
        wb.alu_result_in  = v;
        wb.imm_in         = v;
        wb.pc_in          = v;
        wb.csr_data_in    = v;
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns,
                      input logic [1:0] off, input logic [4:0] rd);
        op(3'b001, rd, 32'h0);
        wb.load_size_in     = sz;
        wb.load_unsigned_in = uns;
        wb.load_addr_lsb_in = off;
    endtask

    task automatic chk_idle_rst(input string tag);
        chk({tag, "_rd"}, wb.rd_out, 32'h0);
        chk({tag, "_addr"}, 32'(wb.rd_addr_out), 32'h0);
        chk({tag, "_we"}, 32'(wb.wr_en_out), 32'h0);
        chk({tag, "_err"}, 32'(wb.load_err_out), 32'h0);
        chk({tag, "_rdy"}, 32'(wb.wb_ready_out), 32'h1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        wb.instr_valid_in   = 1'b0;
        wb.rf_wr_en_in      = 1'b0;
        wb.rd_addr_in       = 5'd0;
        wb.wb_mux_sel_in    = 3'b000;
        wb.alu_result_in    = 32'h0;
        wb.imm_in           = 32'h0;
        wb.pc_in            = 32'h0;
        wb.csr_data_in      = 32'h0;
        wb.load_size_in     = 2'b00;
        wb.load_unsigned_in = 1'b0;
        wb.load_addr_lsb_in = 2'b00;
        wb.dmem_rdata_in    = 32'h0;
        wb.dmem_rvalid_in   = 1'b0;
        #2;
        chk_idle_rst("reset");
        tick();
        rst = 1'b0;
        tick();

        // ALU then LUI back to back
        op(3'b000, 5'd2, 32'h48484848);
        tick();
        chk("alu_we", 32'(wb.wr_en_out), 32'h1);
        chk("alu_rd", wb.rd_out, 32'h48484848);
        chk("alu_addr", 32'(wb.rd_addr_out), 32'd2);
        op(3'b010, 5'd3, 32'h40404000);
        tick();
        chk("lui_we", 32'(wb.wr_en_out), 32'h1);
        chk("lui_rd", wb.rd_out, 32'h40404000);
        chk("lui_addr", 32'(wb.rd_addr_out), 32'd3);
        op(3'b011, 5'd9, 32'hFFFFFFFC);
        tick();
        chk("pc4_we", 32'(wb.wr_en_out), 32'h1);
        chk("pc4_wrap", wb.rd_out, 32'h0);
        op(3'b100, 5'd10, 32'h12345678);
        tick();
        chk("csr_rd", wb.rd_out, 32'h12345678);
        chk("csr_addr", 32'(wb.rd_addr_out), 32'd10);
        wb.instr_valid_in = 1'b0;
        tick();
        chk("idle_we", 32'(wb.wr_en_out), 32'h0);

        // x0 and reserved select
        op(3'b000, 5'd0, 32'h11111111);
        tick();
        chk("x0_we", 32'(wb.wr_en_out), 32'h0);
        op(3'b110, 5'd7, 32'h22222222);
        tick();
        chk("rsv_we", 32'(wb.wr_en_out), 32'h0);
        chk("rsv_addr", 32'(wb.rd_addr_out), 32'd7);
        wb.instr_valid_in = 1'b0;

        // signed byte, offset 3, two empty wait cycles
        ld(2'b00, 1'b0, 2'd3, 5'd5);
        tick();
        wb.instr_valid_in = 1'b0;
        chk("sb_rdy0", 32'(wb.wb_ready_out), 32'h0);
        tick();
        chk("sb_rdy1", 32'(wb.wb_ready_out), 32'h0);
        tick();
        chk("sb_we_wait", 32'(wb.wr_en_out), 32'h0);
        wb.dmem_rvalid_in = 1'b1;
        wb.dmem_rdata_in  = 32'h80FF1234;
        tick();
        wb.dmem_rvalid_in = 1'b0;
        chk("sb_we", 32'(wb.wr_en_out), 32'h1);
        chk("sb_rd", wb.rd_out, 32'hFFFFFF80);
        chk("sb_addr", 32'(wb.rd_addr_out), 32'd5);
        chk("sb_rdy", 32'(wb.wb_ready_out), 32'h1);
        tick();
        chk("sb_pulse", 32'(wb.wr_en_out), 32'h0);

        // unsigned half, offset 2, rvalid in first wait cycle
        ld(2'b01, 1'b1, 2'd2, 5'd6);
        tick();
        wb.instr_valid_in = 1'b0;
        wb.dmem_rvalid_in = 1'b1;
        wb.dmem_rdata_in  = 32'h8001AAAA;
        tick();
        wb.dmem_rvalid_in = 1'b0;
        chk("uh_rd", wb.rd_out, 32'h00008001);
        chk("uh_we", 32'(wb.wr_en_out), 32'h1);

        // signed half offset 0 and word
        ld(2'b01, 1'b0, 2'd0, 5'd8);
        tick();
        wb.instr_valid_in = 1'b0;
        wb.dmem_rvalid_in = 1'b1;
        wb.dmem_rdata_in  = 32'h12348001;
        tick();
        chk("sh_rd", wb.rd_out, 32'hFFFF8001);
        wb.dmem_rvalid_in = 1'b0;
        ld(2'b10, 1'b0, 2'd0, 5'd11);
        tick();
        wb.instr_valid_in = 1'b0;
        wb.dmem_rvalid_in = 1'b1;
        wb.dmem_rdata_in  = 32'hDEADBEEF;
        tick();
        wb.dmem_rvalid_in = 1'b0;
        chk("lw_rd", wb.rd_out, 32'hDEADBEEF);
        chk("lw_addr", 32'(wb.rd_addr_out), 32'd11);

        // misaligned word
        ld(2'b10, 1'b0, 2'd1, 5'd12);
        tick();
        wb.instr_valid_in = 1'b0;
        chk("mis_err", 32'(wb.load_err_out), 32'h1);
        chk("mis_we", 32'(wb.wr_en_out), 32'h0);
        chk("mis_rdy", 32'(wb.wb_ready_out), 32'h1);
        chk("mis_hold", wb.rd_out, 32'hDEADBEEF);
        tick();
        chk("mis_pulse", 32'(wb.load_err_out), 32'h0);

        // timeout after 4 wait cycles
        ld(2'b10, 1'b0, 2'd0, 5'd13);
        tick();
        wb.instr_valid_in = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("to_err_early", 32'(wb.load_err_out), 32'h0);
            chk("to_rdy_wait", 32'(wb.wb_ready_out), 32'h0);
        end
        tick();
        chk("to_err", 32'(wb.load_err_out), 32'h1);
        chk("to_we", 32'(wb.wr_en_out), 32'h0);
        chk("to_rdy", 32'(wb.wb_ready_out), 32'h1);
        chk("to_hold", wb.rd_out, 32'hDEADBEEF);

        // rvalid in last allowed wait cycle is accepted
        ld(2'b00, 1'b1, 2'd1, 5'd14);
        tick();
        wb.instr_valid_in = 1'b0;
        tick();
        tick();
        tick();
        wb.dmem_rvalid_in = 1'b1;
        wb.dmem_rdata_in  = 32'h0000A500;
        tick();
        wb.dmem_rvalid_in = 1'b0;
        chk("last_we", 32'(wb.wr_en_out), 32'h1);
        chk("last_err", 32'(wb.load_err_out), 32'h0);
        chk("last_rd", wb.rd_out, 32'h000000A5);

        // reset during WAIT_LOAD, late rvalid ignored
        ld(2'b10, 1'b0, 2'd0, 5'd15);
        tick();
        wb.instr_valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_idle_rst("mid_rst");
        #2;
        rst = 1'b0;
        wb.dmem_rvalid_in = 1'b1;
        wb.dmem_rdata_in  = 32'hCAFEF00D;
        tick();
        wb.dmem_rvalid_in = 1'b0;
        chk("late_we", 32'(wb.wr_en_out), 32'h0);
        chk("late_rd", wb.rd_out, 32'h0);
        op(3'b000, 5'd4, 32'h0BADC0DE);
        tick();
        wb.instr_valid_in = 1'b0;
        chk("post_we", 32'(wb.wr_en_out), 32'h1);
        chk("post_rd", wb.rd_out, 32'h0BADC0DE);
        chk("post_addr", 32'(wb.rd_addr_out), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
